piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_shreg.sv | 44 ++++
 rtl/piso_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serializer.
//   - piso_state_e  : FSM state encoding (IDLE, SHIFT, PAR)
//   - PisoDefaultWidth : default parallel word width
package piso_pkg;

    localparam int unsigned PisoDefaultWidth = 8;

    // PAR is only reachable when the parity option (PISO_TX_PARITY_EN) is built in.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StPar   = 2'b10
    } piso_state_e;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, left-shifting register for the piso_tx serializer.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset, clears the register
//   load_i   : capture data_i (has priority over shift_i)
//   shift_i  : shift one position towards the MSB, zero fill
//   data_i   : parallel word
//   msb_o    : current MSB, i.e. the bit on the serial line
module piso_shreg
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PisoDefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first.
// Ports:
//   CLK        : clock, rising edge
//   Asynch_clr : asynchronous active-high reset
//   D          : parallel word, sampled only on the accepting edge
//   LOAD       : load request, accepted when READY=1
//   READY      : high while idle and able to accept a word
//   SDO        : serial data out
//   SFRAME     : high while SDO carries a frame bit
//   DONE       : one-cycle pulse after the last frame bit
// Build option: define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PisoDefaultWidth
) (
    input  logic             CLK,
    input  logic             Asynch_clr,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    output logic             READY,
    output logic             SDO,
    output logic             SFRAME,
    output logic             DONE
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    piso_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            accept;
    logic            shift_en;
    logic            shreg_msb;

`ifdef PISO_TX_PARITY_EN
    // Parity is taken from D at the accepting edge so it tracks the captured word.
    logic par_q, par_d;
`endif

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk_i  (CLK),
        .rst_i  (Asynch_clr),
        .load_i (accept),
        .shift_i(shift_en),
        .data_i (D),
        .msb_o  (shreg_msb)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        shift_en = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (LOAD) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StShift;
`ifdef PISO_TX_PARITY_EN
                    par_d   = ^D;
`endif
                end
            end
            StShift: begin
                shift_en = 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StIdle;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef PISO_TX_PARITY_EN
            StPar: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
`endif
            default: begin
                // Unused encodings fall back to idle without a DONE pulse.
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        READY  = 1'b0;
        SFRAME = 1'b0;
        SDO    = 1'b0;
        case (state_q)
            StIdle:  READY = 1'b1;
            StShift: begin
                SFRAME = 1'b1;
                SDO    = shreg_msb;
            end
`ifdef PISO_TX_PARITY_EN
            StPar: begin
                SFRAME = 1'b1;
                SDO    = par_q;
            end
`endif
            default: begin
                READY  = 1'b0;
            end
        endcase
        DONE = done_q;
    end

    always_ff @(posedge CLK or posedge Asynch_clr) begin
        if (Asynch_clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge CLK or posedge Asynch_clr) begin
        if (Asynch_clr) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule
